// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, bit-serial shifts,
// valid/ready handshakes on input and output, registered result and zero flag.
module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic              zero_reg, zero_next;
  logic              illegal_reg, illegal_next;
  logic [XLEN-1:0]   work_reg, work_next;
  logic [SHW-1:0]    cnt_reg, cnt_next;
  logic [1:0]        shtype_reg, shtype_next;

  logic [XLEN-1:0]   alu_val;
  logic              op_shift;
  logic              op_legal;
  logic [1:0]        sh_type;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   work_shifted;

  assign shamt = op_b[SHW-1:0];

  // Operation decode and single-cycle datapath.
  always_comb begin
    alu_val  = '0;
    op_shift = 1'b0;
    op_legal = 1'b1;
    sh_type  = SH_SLL;
    case (alu_ctrl)
      OP_AND:  alu_val = op_a & op_b;
      OP_OR:   alu_val = op_a | op_b;
      OP_ADD:  alu_val = op_a + op_b;
      OP_XOR:  alu_val = op_a ^ op_b;
      OP_SUB:  alu_val = op_a - op_b;
      OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_SLL: begin
        op_shift = 1'b1;
        sh_type  = SH_SLL;
      end
      OP_SRL: begin
        op_shift = 1'b1;
        sh_type  = SH_SRL;
      end
      OP_SRA: begin
        op_shift = 1'b1;
        sh_type  = SH_SRA;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // One-bit shift step of the working register.
  always_comb begin
    case (shtype_reg)
      SH_SRL:  work_shifted = {1'b0, work_reg[XLEN-1:1]};
      SH_SRA:  work_shifted = {work_reg[XLEN-1], work_reg[XLEN-1:1]};
      default: work_shifted = {work_reg[XLEN-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    work_next    = work_reg;
    cnt_next     = cnt_reg;
    shtype_next  = shtype_reg;
    // flush wins over accept and output handshake; result fields are kept.
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            illegal_next = !op_legal;
            if (!op_legal) begin
              result_next = '0;
              zero_next   = 1'b1;
              state_next  = DONE;
            end else if (op_shift && (shamt != '0)) begin
              work_next   = op_a;
              cnt_next    = shamt;
              shtype_next = sh_type;
              state_next  = SHIFT;
            end else if (op_shift) begin
              result_next = op_a;
              zero_next   = (op_a == '0);
              state_next  = DONE;
            end else begin
              result_next = alu_val;
              zero_next   = (alu_val == '0);
              state_next  = DONE;
            end
          end
        end
        SHIFT: begin
          work_next = work_shifted;
          cnt_next  = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            result_next = work_shifted;
            zero_next   = (work_shifted == '0);
            state_next  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      work_reg    <= '0;
      cnt_reg     <= '0;
      shtype_reg  <= SH_SLL;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
      work_reg    <= work_next;
      cnt_reg     <= cnt_next;
      shtype_reg  <= shtype_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then count cycles until out_valid.
  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    $display("op ctrl=%b a=0x%08h b=0x%08h -> result=0x%08h zero=%0b illegal=%0b latency=%0d",
             ctrl, a, b, result, zero, illegal, lat);
  endtask

  // Verify one completed op; out_ready is high, so the unit returns to IDLE next cycle.
  task automatic expect_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                           input logic exp_zero, input logic exp_ill);
    int lat;
    run_op(ctrl, a, b, lat);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_result"}, result, exp_res);
    check_val({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    check_val({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    tick();
    check_val({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen_ov;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'b0000;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;

    repeat (2) tick();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result", result, 32'h0);
    check_val("rst_zero", 32'(zero), 32'd0);
    check_val("rst_illegal", 32'(illegal), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // Arithmetic, compare and shift vectors
    expect_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0, 1'b0);
    expect_op("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 32'h0, 1'b1, 1'b0);
    expect_op("xor", 4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F, 1'b0, 1'b0);
    expect_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h1, 1'b0, 1'b0);
    expect_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0, 1'b1, 1'b0);

    // sra: busy during shifting, no early out_valid
    alu_ctrl = 4'b1001;
    op_a     = 32'h8000_0000;
    op_b     = 32'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val("sra_busy", 32'(busy), 32'd1);
    check_val("sra_in_ready", 32'(in_ready), 32'd0);
    check_val("sra_early_valid", 32'(out_valid), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    $display("op ctrl=1001 a=0x80000000 b=0x00000004 -> result=0x%08h latency=%0d", result, lat);
    check_val("sra_latency", 32'(lat), 32'd5);
    check_val("sra_result", result, 32'hF800_0000);
    tick();

    expect_op("srl", 4'b0101, 32'h8000_0000, 32'd4, 5, 32'h0800_0000, 1'b0, 1'b0);
    expect_op("sll31", 4'b0100, 32'h0000_0001, 32'd31, 32, 32'h8000_0000, 1'b0, 1'b0);
    expect_op("sll0", 4'b0100, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 1'b0, 1'b0);
    expect_op("shamt_mask0", 4'b0101, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678, 1'b0, 1'b0);
    expect_op("shamt_mask4", 4'b0101, 32'h8000_0000, 32'h0000_0024, 5, 32'h0800_0000, 1'b0, 1'b0);

    // Backpressure: result held, inputs ignored while in DONE
    out_ready = 1'b0;
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, lat);
    check_val("and_latency", 32'(lat), 32'd1);
    alu_ctrl = 4'b0001;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_result", result, 32'h0000_F000);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_val("bp_final_result", result, 32'h0000_F000);
    tick();
    check_val("bp_release_in_ready", 32'(in_ready), 32'd1);
    check_val("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Undefined code, then a legal op clears illegal
    expect_op("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0, 1'b1, 1'b1);
    expect_op("or_clear", 4'b0001, 32'h0000_0001, 32'h0000_0002, 1, 32'h3, 1'b0, 1'b0);

    // Flush in the second SHIFT cycle of sll by 10; concurrent in_valid dropped
    alu_ctrl = 4'b0100;
    op_a     = 32'h0000_0001;
    op_b     = 32'd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush    = 1'b1;
    alu_ctrl = 4'b0010;
    op_a     = 32'd2;
    op_b     = 32'd3;
    in_valid = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    $display("flush during sll: busy=%0b in_ready=%0b result=0x%08h", busy, in_ready, result);
    check_val("flush_busy", 32'(busy), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    check_val("flush_result_kept", result, 32'h3);
    seen_ov = out_valid;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_ov = seen_ov | out_valid;
    end
    check_val("flush_no_out_valid", 32'(seen_ov), 32'd0);

    // Async reset in the middle of a shift
    alu_ctrl = 4'b0100;
    op_a     = 32'h0000_0001;
    op_b     = 32'd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    $display("reset mid-shift: busy=%0b out_valid=%0b result=0x%08h", busy, out_valid, result);
    check_val("rstmid_busy", 32'(busy), 32'd0);
    check_val("rstmid_out_valid", 32'(out_valid), 32'd0);
    check_val("rstmid_result", result, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    expect_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that sits directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code and two operands, and produces a registered result plus a zero flag for branch resolution.
- Logical, arithmetic and compare ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, to avoid a barrel shifter.
- Valid/ready handshakes on both input and output let the pipeline stall around multi-cycle shifts.

Parameters:
XLEN, 32, operand/result width (power of two, >= 8)
SHW, $clog2(XLEN), shift-amount width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight operation
in_valid  input  1  operands and alu_ctrl are valid
in_ready  output  1  unit can accept an operation
alu_ctrl  input  4  operation code from the ALU control decoder
op_a  input  XLEN  operand A (shift source)
op_b  input  XLEN  operand B (shift amount = op_b[SHW-1:0])
out_valid  output  1  result, zero and illegal are valid
out_ready  input  1  consumer accepts the result
result  output  XLEN  registered result
zero  output  1  result == 0
illegal  output  1  alu_ctrl was an undefined code
busy  output  1  operation in flight (state != IDLE)

Behaviour:
- Reset: async, active-low. State=IDLE; result=0; zero=0; illegal=0; out_valid=0. in_ready=1 once reset is deasserted.
- Codes:
  - 0000 and, 0001 or, 0010 add, 0011 xor, 0110 sub
  - 0111 slt (signed), 1000 sltu (unsigned); slt/sltu result is zero-extended 0/1
  - 0100 sll, 0101 srl, 1001 sra
  - all other codes are undefined
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Input is accepted when in_valid && in_ready.
  - Non-shift op: result is computed and registered, next state DONE (latency 1).
  - Undefined code: result=0, illegal=1, next state DONE.
  - Shift op with shamt=0: result=op_a, next state DONE.
  - Shift op with shamt!=0: load working reg=op_a, counter=shamt, latch shift type, next state SHIFT.
- SHIFT:
  - Each cycle, shift the working reg by 1 bit: sll inserts 0 at the LSB; srl inserts 0 at the MSB; sra replicates the MSB.
  - Counter decrements each cycle.
  - When the counter reaches 1 (the final shift cycle), the shifted value goes into result and next state is DONE.
  - Latency from accept to out_valid = shamt+1 cycles.
- DONE:
  - out_valid=1; result/zero/illegal are held stable while out_ready=0.
  - On out_valid && out_ready, next state is IDLE and out_valid drops the following cycle.
  - The next input is not accepted in the same cycle (in_ready=0 in DONE). Maximum throughput is one op per 2 cycles.
- in_ready is 0 in SHIFT and DONE; inputs are ignored there regardless of in_valid.
- zero = (result == 0), registered together with result. Also valid for illegal ops (zero=1, since result=0).
- illegal clears on the next accepted legal op.
- flush:
  - Highest synchronous priority; overrides accept and handshake in the same cycle.
  - Forces state=IDLE and out_valid=0 next cycle; result/zero/illegal retain their values.
  - An in_valid in the flush cycle is dropped.
- Reset mid-SHIFT or mid-DONE: immediate return to the reset values; the operation is lost.
- Shift amount uses op_b[SHW-1:0] only; upper bits are ignored.

Test Plan:
- add 0x7FFFFFFF+0x00000001, out_ready=1 -> out_valid 1 cycle after accept, result=0x80000000, zero=0; sub 5-5 -> result=0, zero=1.
- sra op_a=0x80000000, op_b=4 -> busy for 4 cycles, out_valid at accept+5, result=0xF8000000; srl same operands -> 0x08000000; sll 0x1 by 31 -> 0x80000000 at accept+32; shamt=0 -> result=op_a at accept+1.
- slt op_a=0xFFFFFFFF, op_b=0x00000001 -> result=1; sltu same operands -> result=0; op_b=0x00000024 shift -> shamt=4 used.
- Backpressure: and 0xF0F0 & 0xFF00, out_ready=0 for 3 cycles -> result=0x0000F000 held stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
- alu_ctrl=1111 -> out_valid at accept+1, result=0, zero=1, illegal=1; next legal op clears illegal.
- flush at 2nd SHIFT cycle of sll by 10 -> out_valid never asserts, IDLE and in_ready=1 next cycle; rst_n low mid-SHIFT -> immediate IDLE, out_valid=0, result=0.
